codec_init_seq: RTL
===================

CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 Parameter CLK_DIV, default 125, clk cycles per SCL quarter-bit; 50 MHz clk gives 100 kHz SCL.
REQ-002 Parameter DEV_ADDR, default 7'h1A, codec 7-bit I2C address.
REQ-003 Parameter MAX_RETRY, default 3, NACK retries per register word.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to run the full init table.
REQ-007 busy  out  1  sequence in progress.
REQ-008 done  out  1  all words acknowledged; held until next accepted start or Reset.
REQ-009 error  out  1  retries exhausted; held until next accepted start or Reset.
REQ-010 reg_index  out  4  table index of the word currently or last sent.
REQ-011 i2c_scl  out  1  SCL; 1 = released, 0 = driven low.
REQ-012 i2c_sda_oe  out  1  1 = drive SDA low, 0 = release.
REQ-013 i2c_sda_in  in  1  sampled SDA line.

Function
REQ-014 Sequencer SHALL write 10 table words in index order 0..9, each as one I2C transaction: START, {DEV_ADDR,0}, word[15:8], word[7:0], STOP, MSB first.
REQ-015 Table contents SHALL be, in order: 1E00, 0017, 0217, 0479, 0679, 0812, 0A06, 0C00, 0E42, 1201 (hex).
REQ-016 start SHALL be accepted only in IDLE, DONE or ERR; start in any other state SHALL be ignored.
REQ-017 On acceptance, busy SHALL rise next cycle, done, error and reg_index SHALL clear, and SDA SHALL fall while SCL is high within CLK_DIV cycles.
REQ-018 Each bit SHALL take 4 quarter-phases of CLK_DIV cycles with SCL low, high, high, low; SDA SHALL change only in the first phase; sampling SHALL occur at the end of the second phase.
REQ-019 The 9th bit of each byte SHALL release SDA and sample i2c_sda_in; 0 = ACK, 1 = NACK.
REQ-020 Controller FSM states SHALL be IDLE, START, BYTE, ACK, STOP, GAP, NEXT, DONE, ERR.
REQ-021 After STOP, GAP SHALL hold both lines released for 4*CLK_DIV cycles before the next START.
REQ-022 On NACK, the controller SHALL complete STOP and GAP, then restart the same word from START with its retry counter incremented.
REQ-023 The retry counter SHALL reset to 0 on each new word.
REQ-024 A NACK when the retry count equals MAX_RETRY SHALL issue STOP, then enter ERR with error=1, busy=0, and reg_index at the failing word.
REQ-025 After word 9 is ACKed and STOP completes, the FSM SHALL enter DONE with done=1, busy=0 and reg_index=9.
REQ-026 done and error SHALL never both be 1.

Reset
REQ-027 While Reset=1 at a clk edge, the state SHALL become IDLE, i2c_scl=1, i2c_sda_oe=0, busy=0, done=0, error=0, reg_index=0, and all counters SHALL be 0.
REQ-028 Reset mid-transaction SHALL abort immediately with no STOP; the lines SHALL be released at that edge.

Configuration
REQ-029 Macro CODEC_INIT_RETRY_EN: when defined, NACK handling SHALL follow REQ-022..024.
REQ-030 When CODEC_INIT_RETRY_EN is undefined, the first NACK SHALL issue STOP and enter ERR; MAX_RETRY SHALL be unused.

Structure
REQ-031 Package codec_init_pkg SHALL hold the init table constant, NUM_REGS=10, and the FSM state enum.
REQ-032 Sub-module codec_i2c_phy SHALL generate quarter-phase ticks and perform START, STOP and byte+ACK operations through a cmd/ready/ack handshake.
REQ-033 codec_init_seq SHALL own table walking and retry logic.

Verification
REQ-034 Slave model ACKs all bytes; pulse start -> 10 transactions with bytes 34 1E 00, 34 00 17 ... 34 12 01, then done=1 and busy=0.
REQ-035 Measure SCL with CLK_DIV=4 -> SCL period of exactly 16 clk cycles, and SDA stable whenever SCL is high except at START and STOP.
REQ-036 Slave NACKs the first attempt of word 3 with retry enabled -> word 3 is sent twice, then done=1 and error=0.
REQ-037 Slave always NACKs word 3 -> with CODEC_INIT_RETRY_EN, 4 attempts, then error=1 and reg_index=3; without CODEC_INIT_RETRY_EN, 1 attempt, then error=1.
REQ-038 Pulse start while busy -> no effect; assert Reset mid-byte -> next edge shows i2c_scl=1, i2c_sda_oe=0, busy=0.
REQ-039 Pulse start in DONE -> done clears next cycle and the full 10-word sequence repeats.

Source files
------------

// File: rtl/codec_init_pkg.sv
// Shared constants for the codec init sequencer: register table, controller
// state encoding and the command codes understood by the I2C bit engine.
package codec_init_pkg;

    localparam int unsigned NUM_REGS = 10;

    // Entry 0 is the least significant slice; words go out in index order.
    localparam logic [NUM_REGS-1:0][15:0] INIT_TABLE = {
        16'h1201, 16'h0E42, 16'h0C00, 16'h0A06, 16'h0812,
        16'h0679, 16'h0479, 16'h0217, 16'h0017, 16'h1E00
    };

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t StIdle  = 4'd0;
    localparam seq_state_t StStart = 4'd1;
    localparam seq_state_t StByte  = 4'd2;
    localparam seq_state_t StAck   = 4'd3;
    localparam seq_state_t StStop  = 4'd4;
    localparam seq_state_t StGap   = 4'd5;
    localparam seq_state_t StNext  = 4'd6;
    localparam seq_state_t StDone  = 4'd7;
    localparam seq_state_t StErr   = 4'd8;

    typedef logic [1:0] phy_op_t;

    localparam phy_op_t OpIdle  = 2'd0;
    localparam phy_op_t OpStart = 2'd1;
    localparam phy_op_t OpByte  = 2'd2;
    localparam phy_op_t OpStop  = 2'd3;

endpackage

// File: rtl/codec_i2c_phy.sv
// I2C bit engine: quarter-phase timing, START, STOP and byte+ACK operations
// accepted through a cmd/ready handshake with a one-cycle completion pulse.
module codec_i2c_phy
    import codec_init_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       cmd_valid_i,
    input  phy_op_t    cmd_i,
    input  logic [7:0] cmd_byte_i,
    output logic       cmd_ready_o,
    output logic       cmd_ack_o,
    output logic       nack_o,
    output logic       scl_o,
    output logic       sda_oe_o,
    input  logic       sda_i
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    phy_op_t          op_q, op_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             nack_q, nack_d;
    logic             held_q, held_d;
    logic             qtick;
    logic             op_end;

    assign qtick = (div_q == DivLast);

    always_comb begin
        case (op_q)
            OpStart: op_end = qtick && (qtr_q == 2'd1);
            OpByte:  op_end = qtick && (qtr_q == 2'd3) && (bit_q == 4'd8);
            OpStop:  op_end = qtick && (qtr_q == 2'd2);
            default: op_end = 1'b0;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        nack_d  = nack_q;
        held_d  = held_q;
        if (op_q == OpIdle) begin
            div_d = '0;
            qtr_d = '0;
            bit_d = '0;
            if (cmd_valid_i) begin
                op_d    = cmd_i;
                shift_d = cmd_byte_i;
            end
        end else begin
            div_d = qtick ? '0 : div_q + DivW'(1);
            if (qtick) begin
                qtr_d = qtr_q + 2'd1;
                if (op_q == OpByte && qtr_q == 2'd1 && bit_q == 4'd8) begin
                    nack_d = sda_i;
                end
                if (op_q == OpByte && qtr_q == 2'd3) begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                end
            end
            if (op_end) begin
                op_d = OpIdle;
                // SCL stays owned (held low) from START until STOP completes.
                if (op_q == OpStart) held_d = 1'b1;
                if (op_q == OpStop)  held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            op_q    <= OpIdle;
            div_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            nack_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            nack_q  <= nack_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        case (op_q)
            OpStart: begin
                scl_o    = (qtr_q == 2'd0);
                sda_oe_o = 1'b1;
            end
            OpByte: begin
                scl_o    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_oe_o = (bit_q != 4'd8) && !shift_q[7];
            end
            OpStop: begin
                scl_o    = (qtr_q != 2'd0);
                sda_oe_o = (qtr_q != 2'd2);
            end
            default: begin
                scl_o    = !held_q;
                sda_oe_o = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o = (op_q == OpIdle);
    assign cmd_ack_o   = op_end;
    assign nack_o      = nack_q;

endmodule

// File: rtl/codec_init_seq.sv
// Codec init sequencer: writes the register table over I2C, word by word.
// Optional CODEC_INIT_RETRY_EN re-sends a NACKed word up to MAX_RETRY times.
module codec_init_seq
    import codec_init_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 125,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] reg_index,
    output logic       i2c_scl,
    output logic       i2c_sda_oe,
    input  logic       i2c_sda_in
);

    localparam int unsigned GapW = $clog2(4 * CLK_DIV);
    localparam logic [GapW-1:0] GapLast = GapW'(4 * CLK_DIV - 1);

    seq_state_t       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [1:0]       byte_q, byte_d;
    logic             nack_q, nack_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             can_retry;

    logic             phy_valid;
    phy_op_t          phy_cmd;
    logic [7:0]       phy_byte;
    logic             phy_ready;
    logic             phy_ack;
    logic             phy_nack;
    logic [15:0]      word;

`ifdef CODEC_INIT_RETRY_EN
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RetryW-1:0] retry_q, retry_d;
    assign can_retry = (retry_q != RetryW'(MAX_RETRY));
`else
    assign can_retry = 1'b0;
`endif

    assign word = INIT_TABLE[idx_q];

    always_comb begin
        case (byte_q)
            2'd0:    phy_byte = {DEV_ADDR, 1'b0};
            2'd1:    phy_byte = word[15:8];
            default: phy_byte = word[7:0];
        endcase
    end

    always_comb begin
        case (state_q)
            StStart: phy_cmd = OpStart;
            StByte:  phy_cmd = OpByte;
            StStop:  phy_cmd = OpStop;
            default: phy_cmd = OpIdle;
        endcase
    end

    // Ready drops at acceptance and the state moves on the ack edge, so a
    // held request is never taken twice.
    assign phy_valid = (phy_cmd != OpIdle) && phy_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        nack_d  = nack_q;
        gap_d   = gap_q;
`ifdef CODEC_INIT_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StStart;
                    idx_d   = '0;
                    byte_d  = '0;
                    nack_d  = 1'b0;
                    gap_d   = '0;
`ifdef CODEC_INIT_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            StStart: begin
                if (phy_ack) begin
                    state_d = StByte;
                    byte_d  = '0;
                end
            end
            StByte: begin
                if (phy_ack) begin
                    state_d = StAck;
                    nack_d  = phy_nack;
                end
            end
            StAck: begin
                if (nack_q || byte_q == 2'd2) begin
                    state_d = StStop;
                end else begin
                    state_d = StByte;
                    byte_d  = byte_q + 2'd1;
                end
            end
            StStop: begin
                if (phy_ack) begin
                    if (nack_q) begin
                        state_d = can_retry ? StGap : StErr;
                    end else if (idx_q == 4'(NUM_REGS - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q + GapW'(1);
                if (gap_q == GapLast) begin
                    gap_d = '0;
                    if (nack_q) begin
                        state_d = StStart;
                        nack_d  = 1'b0;
`ifdef CODEC_INIT_RETRY_EN
                        retry_d = retry_q + RetryW'(1);
`endif
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                state_d = StStart;
                idx_d   = idx_q + 4'd1;
`ifdef CODEC_INIT_RETRY_EN
                retry_d = '0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            byte_q  <= '0;
            nack_q  <= 1'b0;
            gap_q   <= '0;
`ifdef CODEC_INIT_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            nack_q  <= nack_d;
            gap_q   <= gap_d;
`ifdef CODEC_INIT_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    codec_i2c_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk         (clk),
        .Reset       (Reset),
        .cmd_valid_i (phy_valid),
        .cmd_i       (phy_cmd),
        .cmd_byte_i  (phy_byte),
        .cmd_ready_o (phy_ready),
        .cmd_ack_o   (phy_ack),
        .nack_o      (phy_nack),
        .scl_o       (i2c_scl),
        .sda_oe_o    (i2c_sda_oe),
        .sda_i       (i2c_sda_in)
    );

    assign busy      = !(state_q == StIdle || state_q == StDone || state_q == StErr);
    assign done      = (state_q == StDone);
    assign error     = (state_q == StErr);
    assign reg_index = idx_q;

endmodule
